// File: rtl/ysyx_25060170_pkg.sv
// rtl/ysyx_25060170_pkg.sv - shared constants and FSM encoding for the instruction fetch unit
package ysyx_25060170_pkg;

  localparam int unsigned      ILEN             = 32;
  localparam logic [ILEN-1:0] PC_STEP          = 32'd4;
  localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_EXEC    = 3'd4,
    S_FAULT   = 3'd5
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25060170_pc_gen.sv
// rtl/ysyx_25060170_pc_gen.sv - next-PC selection and PC register (alignment check under YSYX_25060170_IFU_ALIGN_CHECK_EN)
module ysyx_25060170_pc_gen
  import ysyx_25060170_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            jump_en,
  input  logic [ILEN-1:0] jump_target,
  output logic [ILEN-1:0] pc,
  output logic            misaligned
);

  logic [ILEN-1:0] next_raw;
  logic [ILEN-1:0] next_pc;

  // Redirect target has bit 0 cleared like jalr; sequential step wraps modulo 2^32
  always_comb begin
    next_raw = jump_en ? (jump_target & ~32'h1) : (pc + PC_STEP);
`ifdef YSYX_25060170_IFU_ALIGN_CHECK_EN
    next_pc    = next_raw;
    misaligned = |(next_raw & 32'h3);
`else
    next_pc    = next_raw & ~32'h3;
    misaligned = 1'b0;
`endif
  end

  // PC register: loaded only when the current instruction retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// rtl/ysyx_25060170_ifu.sv - multi-cycle instruction fetch unit (optional YSYX_25060170_IFU_ALIGN_CHECK_EN fault)
module ysyx_25060170_ifu
  import ysyx_25060170_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [ILEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [ILEN-1:0] inst_o,
  output logic [ILEN-1:0] pc_o,
  input  logic            wb_valid_i,
  input  logic            wb_jump_en_i,
  input  logic [ILEN-1:0] wb_jump_target_i,
  output logic            fault_o
);

  ifu_state_e state;
  ifu_state_e state_next;
  logic       pc_load;
  logic       pc_misaligned;

  // Retirement is only honoured while an instruction is executing
  assign pc_load       = (state == S_EXEC) && wb_valid_i;
  assign imem_req_addr = pc_o;

  ysyx_25060170_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .jump_en    (wb_jump_en_i),
    .jump_target(wb_jump_target_i),
    .pc         (pc_o),
    .misaligned (pc_misaligned)
  );

  // State register; reset abandons any in-flight fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one outstanding fetch, strictly sequential phases
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    state_next = S_REQ;
      S_REQ:     if (imem_req_ready) state_next = S_WAIT;
      S_WAIT:    if (imem_rsp_valid) state_next = S_DELIVER;
      S_DELIVER: if (inst_ready_i) state_next = S_EXEC;
      S_EXEC:    if (wb_valid_i) state_next = pc_misaligned ? S_FAULT : S_REQ;
      S_FAULT:   state_next = S_FAULT;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state
  always_comb begin
    imem_req_valid = (state == S_REQ);
    inst_valid_o   = (state == S_DELIVER);
`ifdef YSYX_25060170_IFU_ALIGN_CHECK_EN
    fault_o        = (state == S_FAULT);
`else
    fault_o        = 1'b0;
`endif
  end

  // Instruction register: captures only the response to the outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o <= '0;
    end else if ((state == S_WAIT) && imem_rsp_valid) begin
      inst_o <= imem_rsp_data;
    end
  end

endmodule
